// File: rtl/gf16_power_unit_if.sv
// Request/response bundle for gf16_power_unit: valid/ready on both sides plus status.
// slave is the engine side, master the requester/consumer side.
interface gf16_power_unit_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned EXP_W = 4
);
    logic                 valid_i;
    logic                 ready_o;
    logic [4*LANES-1:0]   operand_i;
    logic [EXP_W-1:0]     exponent_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [4*LANES-1:0]   result_o;
    logic                 busy_o;

    modport slave (
        input  valid_i,
        input  operand_i,
        input  exponent_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output result_o,
        output busy_o
    );

    modport master (
        output valid_i,
        output operand_i,
        output exponent_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  result_o,
        input  busy_o
    );
endinterface

// File: rtl/gf16_power_unit.sv
// Multi-lane GF(2^4) exponentiation, P(x)=x^4+x+1, MSB-first square-and-multiply,
// one exponent bit per cycle, one operation in flight.
module gf16_power_unit #(
    parameter int unsigned LANES = 4,
    parameter int unsigned EXP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gf16_power_unit_if.slave  bus
);
    localparam int unsigned CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int unsigned DW    = 4 * LANES;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     base_q, base_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     result_q, result_d;
    logic [DW-1:0]     acc_step;

    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    // Shift-and-add multiply, reducing x^4 -> x+1 at each shift.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    always_comb begin
        acc_step = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            acc_step[4*k +: 4] = exp_q[cnt_q] ? gf_mul(gf_sq(acc_q[4*k +: 4]), base_q[4*k +: 4])
                                              : gf_sq(acc_q[4*k +: 4]);
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    base_d  = bus.operand_i;
                    exp_d   = bus.exponent_i;
                    acc_d   = {LANES{4'h1}};
                    cnt_d   = CNT_W'(EXP_W - 1);
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    result_d = acc_step;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                if (bus.ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            base_q   <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.busy_o   = (state_q == StRun) || (state_q == StDone);
    assign bus.result_o = result_q;
endmodule
